// File: rtl/cmul_pkg.sv
// rtl/cmul_pkg.sv - shared types and constants for the complex-multiply sequencer
package cmul_pkg;

    localparam int W_DEF = 24;
    localparam int ACC_W = W_DEF + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Product order through the shared multiplier; bit 1 set means imaginary part
    localparam logic [1:0] P_RR = 2'd0;
    localparam logic [1:0] P_II = 2'd1;
    localparam logic [1:0] P_RI = 2'd2;
    localparam logic [1:0] P_IR = 2'd3;

    // Clamp limits for the default width: [-2^23, 2^23-1]
    localparam logic signed [ACC_W-1:0] SAT_MAX = {3'b000, {(W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {3'b111, {(W_DEF-1){1'b0}}};

    // Tag that follows each issued product until its mul_c returns
    typedef struct packed {
        logic       vld;
        logic       neg;
        logic [1:0] idx;
    } tag_t;

endpackage

// File: rtl/cmul_vedic_seq_if.sv
// rtl/cmul_vedic_seq_if.sv - operand/result handshake and multiplier bus of the sequencer
interface cmul_vedic_seq_if
    import cmul_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] ar;
    logic [W-1:0] ai;
    logic [W-1:0] br;
    logic [W-1:0] bi;
    logic [W-1:0] mul_a;
    logic [W-1:0] mul_b;
    logic [W-1:0] mul_c;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] yr;
    logic [W-1:0] yi;
    logic         ovf;

    modport master (
        output in_valid, ar, ai, br, bi, mul_c, out_ready,
        input  in_ready, mul_a, mul_b, out_valid, yr, yi, ovf
    );

    modport slave (
        input  in_valid, ar, ai, br, bi, mul_c, out_ready,
        output in_ready, mul_a, mul_b, out_valid, yr, yi, ovf
    );
endinterface

// File: rtl/cmul_mag_split.sv
// rtl/cmul_mag_split.sv - signed two's complement to sign + unsigned magnitude
module cmul_mag_split
    import cmul_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] val,
    output logic         sign,
    output logic [W-1:0] mag
);
    // The most negative value maps to 100..0, which is its exact magnitude
    assign sign = val[W-1];
    assign mag  = sign ? (~val + 1'b1) : val;
endmodule

// File: rtl/cmul_vedic_seq.sv
// rtl/cmul_vedic_seq.sv - complex-multiply sequencer over one shared unsigned multiplier; CMUL_SAT_EN selects clamping
module cmul_vedic_seq
    import cmul_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int MUL_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    cmul_vedic_seq_if.slave bus
);
    localparam int AW = W + 2;

    state_t               state, state_nxt;
    logic [W-1:0]         op_ar, op_ai, op_br, op_bi;
    logic [W-1:0]         mul_a, mul_b;
    logic [W-1:0]         sel_a, sel_b, mag_a, mag_b;
    logic                 sgn_a, sgn_b;
    tag_t                 iss;
    tag_t                 pipe [MUL_LAT];
    tag_t                 tail;
    logic                 hs, issue, busy, form, neg_eff;
    logic signed [AW-1:0] acc_re, acc_im, acc_re_nxt, acc_im_nxt, mag_ext, term;
    logic [W-1:0]         yr, yi, res_re, res_im;
    logic                 ovf, res_ovf;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.mul_a     = mul_a;
    assign bus.mul_b     = mul_b;
    assign bus.yr        = yr;
    assign bus.yi        = yi;
    assign bus.ovf       = ovf;

    assign hs    = bus.in_valid && (state == IDLE);
    assign issue = hs || ((state == ISSUE) && (iss.idx != P_IR));
    assign form  = (state == DRAIN) && !busy;

    // Pick the operand pair for the next issue: live inputs on accept, latched ones after
    always_comb begin
        sel_a = bus.ar;
        sel_b = bus.br;
        if (state != IDLE) begin
            case (iss.idx)
                P_RR:    begin sel_a = op_ai; sel_b = op_bi; end
                P_II:    begin sel_a = op_ar; sel_b = op_bi; end
                default: begin sel_a = op_ai; sel_b = op_br; end
            endcase
        end
    end

    cmul_mag_split #(.W(W)) u_split_a (.val(sel_a), .sign(sgn_a), .mag(mag_a));
    cmul_mag_split #(.W(W)) u_split_b (.val(sel_b), .sign(sgn_b), .mag(mag_b));

    // Busy while any product is still ahead of the last tag stage
    always_comb begin
        busy = iss.vld;
        for (int k = 0; k < MUL_LAT - 1; k++) begin
            busy = busy | pipe[k].vld;
        end
    end

    // Fold the returning product into real or imaginary; ai*bi enters real negated
    always_comb begin
        tail       = pipe[MUL_LAT-1];
        neg_eff    = tail.neg ^ (tail.idx == P_II);
        mag_ext    = {2'b00, bus.mul_c};
        term       = neg_eff ? -mag_ext : mag_ext;
        acc_re_nxt = acc_re;
        acc_im_nxt = acc_im;
        if (tail.vld) begin
            if (tail.idx[1]) acc_im_nxt = acc_im + term;
            else             acc_re_nxt = acc_re + term;
        end
    end

`ifdef CMUL_SAT_EN
    localparam logic signed [AW-1:0] SAT_HI = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {3'b111, {(W-1){1'b0}}};
`endif

    // Reduce the final accumulators to W bits
    always_comb begin
        res_re  = acc_re_nxt[W-1:0];
        res_im  = acc_im_nxt[W-1:0];
        res_ovf = 1'b0;
`ifdef CMUL_SAT_EN
        if (acc_re_nxt > SAT_HI) begin
            res_re = SAT_HI[W-1:0]; res_ovf = 1'b1;
        end else if (acc_re_nxt < SAT_LO) begin
            res_re = SAT_LO[W-1:0]; res_ovf = 1'b1;
        end
        if (acc_im_nxt > SAT_HI) begin
            res_im = SAT_HI[W-1:0]; res_ovf = 1'b1;
        end else if (acc_im_nxt < SAT_LO) begin
            res_im = SAT_LO[W-1:0]; res_ovf = 1'b1;
        end
`else
        res_ovf = 1'b0;
`endif
    end

    // Sequencing state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: accept, four issues, drain the tag pipe, hold until taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = ISSUE;
            ISSUE:   if (iss.idx == P_IR) state_nxt = DRAIN;
            DRAIN:   if (!busy) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch, multiplier drive, tag pipe, accumulators and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_ar  <= '0;
            op_ai  <= '0;
            op_br  <= '0;
            op_bi  <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            iss    <= '0;
            for (int k = 0; k < MUL_LAT; k++) pipe[k] <= '0;
            acc_re <= '0;
            acc_im <= '0;
            yr     <= '0;
            yi     <= '0;
            ovf    <= 1'b0;
        end else begin
            if (hs) begin
                op_ar <= bus.ar;
                op_ai <= bus.ai;
                op_br <= bus.br;
                op_bi <= bus.bi;
            end
            mul_a   <= issue ? mag_a : '0;
            mul_b   <= issue ? mag_b : '0;
            iss.vld <= issue;
            iss.neg <= sgn_a ^ sgn_b;
            iss.idx <= hs ? P_RR : (issue ? iss.idx + 2'd1 : iss.idx);
            pipe[0] <= iss;
            for (int k = 1; k < MUL_LAT; k++) pipe[k] <= pipe[k-1];
            if (hs) begin
                acc_re <= '0;
                acc_im <= '0;
            end else begin
                acc_re <= acc_re_nxt;
                acc_im <= acc_im_nxt;
            end
            if (form) begin
                yr  <= res_re;
                yi  <= res_im;
                ovf <= res_ovf;
            end
        end
    end
endmodule

// File: tb/tb_cmul_vedic_seq.sv
// tb/tb_cmul_vedic_seq.sv - self-checking bench for cmul_vedic_seq at MUL_LAT 1 and 3
module tb_cmul_vedic_seq;
    import cmul_pkg::*;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] s_ar = '0, s_ai = '0, s_br = '0, s_bi = '0;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cmul_vedic_seq_if #(.W(W)) bus0 ();
    cmul_vedic_seq_if #(.W(W)) bus1 ();

    cmul_vedic_seq #(.W(W), .MUL_LAT(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    cmul_vedic_seq #(.W(W), .MUL_LAT(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    assign bus0.in_valid = in_valid;  assign bus1.in_valid = in_valid;
    assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;
    assign bus0.ar = s_ar; assign bus0.ai = s_ai; assign bus0.br = s_br; assign bus0.bi = s_bi;
    assign bus1.ar = s_ar; assign bus1.ai = s_ai; assign bus1.br = s_br; assign bus1.bi = s_bi;

    // Multiplier stand-in: c = (a*b)>>23, delayed by the DUT's latency
    function automatic logic [W-1:0] mulq(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        return p[2*W-2:W-1];
    endfunction

    logic [W-1:0] m0;
    logic [W-1:0] m1 [3];
    always @(posedge clk) begin
        m0    <= mulq(bus0.mul_a, bus0.mul_b);
        m1[0] <= mulq(bus1.mul_a, bus1.mul_b);
        m1[1] <= m1[0];
        m1[2] <= m1[1];
    end
    assign bus0.mul_c = m0;
    assign bus1.mul_c = m1[2];

    logic [1:0]   in_rdy, out_vld, ovf_o;
    logic [W-1:0] y_r [2], y_i [2], ma [2], mb [2];
    assign in_rdy  = {bus1.in_ready, bus0.in_ready};
    assign out_vld = {bus1.out_valid, bus0.out_valid};
    assign ovf_o   = {bus1.ovf, bus0.ovf};
    assign y_r[0] = bus0.yr;    assign y_r[1] = bus1.yr;
    assign y_i[0] = bus0.yi;    assign y_i[1] = bus1.yi;
    assign ma[0]  = bus0.mul_a; assign ma[1]  = bus1.mul_a;
    assign mb[0]  = bus0.mul_b; assign mb[1]  = bus1.mul_b;

    int lat [2] = '{1, 3};

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %h expected %h (t=%0t)", d, nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Real product of two Q1.23 values through a magnitude multiplier with truncation
    function automatic longint sprod(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = ((sa < 0 ? -sa : sa) * (sb < 0 ? -sb : sb)) >>> 23;
        return ((sa < 0) != (sb < 0)) ? -p : p;
    endfunction

    function automatic void model(input logic [W-1:0] ar, ai, br, bi,
                                  output logic [W-1:0] yr, yi, output logic ov);
        longint re, im;
        re = sprod(ar, br) - sprod(ai, bi);
        im = sprod(ar, bi) + sprod(ai, br);
        ov = 1'b0;
`ifdef CMUL_SAT_EN
        if (re > 64'sd8388607)       begin re = 64'sd8388607;  ov = 1'b1; end
        else if (re < -64'sd8388608) begin re = -64'sd8388608; ov = 1'b1; end
        if (im > 64'sd8388607)       begin im = 64'sd8388607;  ov = 1'b1; end
        else if (im < -64'sd8388608) begin im = -64'sd8388608; ov = 1'b1; end
`endif
        yr = re[W-1:0];
        yi = im[W-1:0];
    endfunction

    logic [1:0]   pend = '0, seen = '0;
    logic [W-1:0] e_yr [2], e_yi [2], p_yr [2], p_yi [2], got_yr [2], got_yi [2];
    logic [1:0]   e_ov, p_ov, got_ov;
    int           hs_cyc [2], last_in_hs [2], last_out_hs [2];

    // Scoreboard: one expected result per DUT, checked every meaningful cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            pend = '0;
            seen = '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (in_valid && in_rdy[d]) begin
                    model(s_ar, s_ai, s_br, s_bi, e_yr[d], e_yi[d], e_ov[d]);
                    pend[d] = 1'b1;
                    seen[d] = 1'b0;
                    hs_cyc[d] = cyc;
                    last_in_hs[d] = cyc;
                end
                if (in_rdy[d] || out_vld[d]) begin
                    chk(d, "mul_a_idle", 32'(ma[d]), 32'd0);
                    chk(d, "mul_b_idle", 32'(mb[d]), 32'd0);
                end
                if (out_vld[d]) begin
                    chk(d, "in_ready_in_done", 32'(in_rdy[d]), 32'd0);
                    if (!seen[d]) begin
                        chk(d, "latency", 32'(cyc - hs_cyc[d]), 32'(5 + lat[d]));
                        chk(d, "result_expected", 32'(pend[d]), 32'd1);
                        seen[d] = 1'b1;
                    end else begin
                        chk(d, "hold_yr", 32'(y_r[d]), 32'(p_yr[d]));
                        chk(d, "hold_yi", 32'(y_i[d]), 32'(p_yi[d]));
                        chk(d, "hold_ovf", 32'(ovf_o[d]), 32'(p_ov[d]));
                    end
                    p_yr[d] = y_r[d];
                    p_yi[d] = y_i[d];
                    p_ov[d] = ovf_o[d];
                    if (out_ready) begin
                        chk(d, "yr", 32'(y_r[d]), 32'(e_yr[d]));
                        chk(d, "yi", 32'(y_i[d]), 32'(e_yi[d]));
                        chk(d, "ovf", 32'(ovf_o[d]), 32'(e_ov[d]));
                        got_yr[d] = y_r[d];
                        got_yi[d] = y_i[d];
                        got_ov[d] = ovf_o[d];
                        pend[d] = 1'b0;
                        last_out_hs[d] = cyc;
                    end
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (in_rdy != 2'b11 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (in_rdy != 2'b11) timeout_fail("wait_idle");
    endtask

    task automatic start_op(input logic [W-1:0] a_r, a_i, b_r, b_i);
        wait_idle();
        s_ar = a_r; s_ai = a_i; s_br = b_r; s_bi = b_i;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        s_ar = 24'h5A5A5A; s_ai = 24'hA5A5A5; s_br = 24'h3C3C3C; s_bi = 24'hC3C3C3;
    endtask

    task automatic wait_done();
        int n = 0;
        while (pend != 2'b00 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        if (pend != 2'b00) timeout_fail("wait_done");
    endtask

    task automatic run_op(input logic [W-1:0] a_r, a_i, b_r, b_i);
        start_op(a_r, a_i, b_r, b_i);
        wait_done();
    endtask

    task automatic lit(input string nm, input logic [W-1:0] yr, yi, input logic ov);
        for (int d = 0; d < 2; d++) begin
            chk(d, {nm, "_yr"}, 32'(got_yr[d]), 32'(yr));
            chk(d, {nm, "_yi"}, 32'(got_yi[d]), 32'(yi));
            chk(d, {nm, "_ovf"}, 32'(got_ov[d]), 32'(ov));
        end
    endtask

    task automatic chk_reset(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk(d, {nm, "_in_ready"}, 32'(in_rdy[d]), 32'd1);
            chk(d, {nm, "_out_valid"}, 32'(out_vld[d]), 32'd0);
            chk(d, {nm, "_mul_a"}, 32'(ma[d]), 32'd0);
            chk(d, {nm, "_mul_b"}, 32'(mb[d]), 32'd0);
            chk(d, {nm, "_yr"}, 32'(y_r[d]), 32'd0);
            chk(d, {nm, "_yi"}, 32'(y_i[d]), 32'd0);
            chk(d, {nm, "_ovf"}, 32'(ovf_o[d]), 32'd0);
        end
    endtask

    logic [W-1:0] my_r, my_i;
    logic         my_o;
    int           n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;

        // Pin the model against hand-computed values
        model(24'h400000, 24'h000000, 24'h400000, 24'h000000, my_r, my_i, my_o);
        chk(0, "model_t1_yr", 32'(my_r), 32'h200000);
        model(24'h400000, 24'h400000, 24'h400000, 24'h400000, my_r, my_i, my_o);
        chk(0, "model_t2_yi", 32'(my_i), 32'h400000);
        model(24'hC00000, 24'h000000, 24'h400000, 24'h000000, my_r, my_i, my_o);
        chk(0, "model_t3_yr", 32'(my_r), 32'hE00000);

        run_op(24'h400000, 24'h000000, 24'h400000, 24'h000000);
        lit("t1", 24'h200000, 24'h000000, 1'b0);
        run_op(24'h400000, 24'h400000, 24'h400000, 24'h400000);
        lit("t2", 24'h000000, 24'h400000, 1'b0);
        run_op(24'hC00000, 24'h000000, 24'h400000, 24'h000000);
        lit("t3", 24'hE00000, 24'h000000, 1'b0);
        run_op(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
`ifdef CMUL_SAT_EN
        lit("t4_max", 24'h000000, 24'h7FFFFF, 1'b1);
`else
        lit("t4_max", 24'h000000, 24'hFFFFFC, 1'b0);
`endif
        run_op(24'h800000, 24'h000000, 24'h800000, 24'h000000);
`ifdef CMUL_SAT_EN
        lit("t4_min", 24'h7FFFFF, 24'h000000, 1'b1);
`else
        lit("t4_min", 24'h800000, 24'h000000, 1'b0);
`endif
        run_op(24'h800000, 24'h800000, 24'h800000, 24'h800000);
        run_op(24'h123456, 24'hFEDCBA, 24'h0ABCDE, 24'hF12345);
        run_op(24'hE00000, 24'h300000, 24'hA00000, 24'h100000);

        // Hold the result in DONE, offer the next operand set meanwhile, then release
        out_ready = 1'b0;
        start_op(24'h200000, 24'h100000, 24'h300000, 24'hF00000);
        n = 0;
        while (out_vld != 2'b11 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (out_vld != 2'b11) timeout_fail("hold_reach_done");
        repeat (10) @(posedge clk);
        #1;
        s_ar = 24'h400000; s_ai = 24'h000000; s_br = 24'h400000; s_bi = 24'h000000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int d = 0; d < 2; d++)
            chk(d, "accept_after_release", 32'(last_in_hs[d]), 32'(last_out_hs[d] + 1));
        wait_done();
        lit("t5_next", 24'h200000, 24'h000000, 1'b0);

        // Abort mid-issue with an asynchronous reset, then run a clean operation
        start_op(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run_op(24'h300000, 24'hD00000, 24'h200000, 24'h100000);
        run_op(24'h400000, 24'h000000, 24'h400000, 24'h000000);
        lit("t6_after", 24'h200000, 24'h000000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
